// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master side drives the request and operands; the slave side returns status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one full-subtractor cell and a registered borrow.
// Results land in output registers on the edge entering DONE and hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave sif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] d_sh_reg, d_sh_next;
    logic             br_reg, br_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             a_msb_reg, a_msb_next;
    logic             b_msb_reg, b_msb_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_out_reg, borrow_out_next;
    logic             overflow_reg, overflow_next;

    // Full-subtractor cell on the current LSBs
    logic x, y, d, bo;
    assign x  = a_sh_reg[0];
    assign y  = b_sh_reg[0];
    assign d  = x ^ y ^ br_reg;
    assign bo = (~x & y) | (~(x ^ y) & br_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            d_sh_reg       <= '0;
            br_reg         <= 1'b0;
            cnt_reg        <= '0;
            a_msb_reg      <= 1'b0;
            b_msb_reg      <= 1'b0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            a_sh_reg       <= a_sh_next;
            b_sh_reg       <= b_sh_next;
            d_sh_reg       <= d_sh_next;
            br_reg         <= br_next;
            cnt_reg        <= cnt_next;
            a_msb_reg      <= a_msb_next;
            b_msb_reg      <= b_msb_next;
            diff_reg       <= diff_next;
            borrow_out_reg <= borrow_out_next;
            overflow_reg   <= overflow_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        a_sh_next       = a_sh_reg;
        b_sh_next       = b_sh_reg;
        d_sh_next       = d_sh_reg;
        br_next         = br_reg;
        cnt_next        = cnt_reg;
        a_msb_next      = a_msb_reg;
        b_msb_next      = b_msb_reg;
        diff_next       = diff_reg;
        borrow_out_next = borrow_out_reg;
        overflow_next   = overflow_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (sif.start) begin
                    a_sh_next  = sif.a;
                    b_sh_next  = sif.b;
                    br_next    = sif.borrow_in;
                    cnt_next   = '0;
                    a_msb_next = sif.a[WIDTH-1];
                    b_msb_next = sif.b[WIDTH-1];
                    state_next = RUN;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                d_sh_next = {d, d_sh_reg[WIDTH-1:1]};
                a_sh_next = {1'b0, a_sh_reg[WIDTH-1:1]};
                b_sh_next = {1'b0, b_sh_reg[WIDTH-1:1]};
                br_next   = bo;
                // Counter stops at WIDTH-1 so it never wraps for power-of-two widths
                if (cnt_reg == LAST) begin
                    state_next      = DONE;
                    diff_next       = d_sh_next;
                    borrow_out_next = bo;
                    overflow_next   = (a_msb_reg != b_msb_reg) & (d != a_msb_reg);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sif.busy       = (state_reg == RUN);
    assign sif.done       = (state_reg == DONE);
    assign sif.diff       = diff_reg;
    assign sif.borrow_out = borrow_out_reg;
    assign sif.overflow   = overflow_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus randomized operations
// compared against an arithmetic model of a - b - borrow_in.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [WIDTH-1:0] prev_diff;
    logic             prev_borrow;
    logic             prev_ovf;

    serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         output logic [WIDTH-1:0] ed, output logic eb, output logic eo);
        int u, s, sa, sb;
        u  = int'(a) - int'(b) - int'(bin);
        sa = (a >= 2 ** (WIDTH - 1)) ? int'(a) - 2 ** WIDTH : int'(a);
        sb = (b >= 2 ** (WIDTH - 1)) ? int'(b) - 2 ** WIDTH : int'(b);
        s  = sa - sb - int'(bin);
        ed = WIDTH'(u);
        eb = (u < 0);
        eo = (s < -(2 ** (WIDTH - 1))) || (s > 2 ** (WIDTH - 1) - 1);
    endtask

    // Called #1 after a rising edge. chain=1 leaves the next run_op to assert start while in DONE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                          input bit glitch, input bit chain);
        logic [WIDTH-1:0] ed;
        logic             eb, eo;
        model(a, b, bin, ed, eb, eo);
        sif.start = 1'b1; sif.a = a; sif.b = b; sif.borrow_in = bin;
        @(posedge clk); #1;
        sif.start = 1'b0;
        sif.a = WIDTH'($urandom); sif.b = WIDTH'($urandom); sif.borrow_in = 1'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            check("busy_run", 32'(sif.busy), 32'd1);
            check("done_run", 32'(sif.done), 32'd0);
            check("diff_hold", 32'(sif.diff), 32'(prev_diff));
            check("flags_hold", {30'd0, sif.borrow_out, sif.overflow}, {30'd0, prev_borrow, prev_ovf});
            if (glitch && i == 2) begin
                sif.start = 1'b1;
                sif.a = WIDTH'($urandom); sif.b = WIDTH'($urandom); sif.borrow_in = 1'($urandom);
            end else begin
                sif.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        sif.start = 1'b0;
        check("done_pulse", 32'(sif.done), 32'd1);
        check("busy_done", 32'(sif.busy), 32'd0);
        check("diff", 32'(sif.diff), 32'(ed));
        check("borrow_out", 32'(sif.borrow_out), 32'(eb));
        check("overflow", 32'(sif.overflow), 32'(eo));
        $display("op a=%02h b=%02h bin=%0d -> diff=%02h bo=%0d ovf=%0d (exp %02h %0d %0d)",
                 a, b, bin, sif.diff, sif.borrow_out, sif.overflow, ed, eb, eo);
        prev_diff = ed; prev_borrow = eb; prev_ovf = eo;
        if (!chain) begin
            @(posedge clk); #1;
            check("done_drop", 32'(sif.done), 32'd0);
            check("busy_idle", 32'(sif.busy), 32'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_ovf    = 1'b0;
        sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.borrow_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(sif.busy), 32'd0);
        check("rst_done", 32'(sif.done), 32'd0);
        check("rst_diff", 32'(sif.diff), 32'd0);
        check("rst_flags", {30'd0, sif.borrow_out, sif.overflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1, 1'b0, 1'b0);
        // Start pulse during RUN must be ignored
        run_op(8'hA5, 8'h17, 1'b0, 1'b1, 1'b0);
        // Back-to-back: second start held in DONE
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        run_op(8'hC8, 8'h64, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation
        sif.start = 1'b1; sif.a = 8'hF0; sif.b = 8'h0F; sif.borrow_in = 1'b0;
        @(posedge clk); #1;
        sif.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(sif.busy), 32'd0);
        check("arst_done", 32'(sif.done), 32'd0);
        check("arst_diff", 32'(sif.diff), 32'd0);
        check("arst_flags", {30'd0, sif.borrow_out, sif.overflow}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("post_rst_done", 32'(sif.done), 32'd0);
            check("post_rst_busy", 32'(sif.busy), 32'd0);
        end

        // Randomized operations with occasional glitches and chaining
        for (int n = 0; n < 40; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
